blink_pattern_sequencer: RTL and testbench
==========================================

# blink_pattern_sequencer

Sequencer that plays a 16-bit blink pattern out one bit at a time. It accepts a pattern over a valid/ready handshake and steps a 4-bit select through 0..15, MSB first, with a programmable bit period. It drives the select lines of the existing 16:1 single-bit mux, which returns `a[15-select]`. It also provides a registered copy of the selected bit for the LED pin.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the bit-period divider and its internal counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pat_valid`  in  1  new pattern offered.
- `pat_ready`  out  1  sequencer can accept a pattern this cycle.
- `pat_data`  in  16  pattern; bit 15 is played first.
- `div`  in  DIV_WIDTH  bit period minus one, in `clk` cycles; sampled at handshake.
- `stop`  in  1  abort playback.
- `sel`  out  4  current bit index; feeds the mux select.
- `bit_out`  out  1  registered value of `pat_reg[15-sel]` while running; 0 when idle.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at pattern completion.

## Operation
- Registers: `state` (IDLE/RUN), `pat_reg[15:0]`, `div_reg`, `cnt` (DIV_WIDTH bits), `sel`, `bit_out`, `done`.
- Reset (async, immediate) forces:
  - `state`=IDLE and `pat_reg`=0, `div_reg`=0, `cnt`=0.
  - Outputs `sel`=0, `bit_out`=0, `busy`=0, `done`=0.
  - `pat_ready`=1 after reset deasserts.
- IDLE:
  - `pat_ready`=1; `stop` is ignored.
  - On `pat_valid && pat_ready`, the sequencer captures `pat_data` and `div`, and sets `sel`=0, `cnt`=0, `bit_out`=`pat_data[15]`, state→RUN.
- RUN, per cycle, in priority order:
  - `stop`=1: state→IDLE, with `sel`=0, `cnt`=0, `bit_out`=0. No `done` pulse.
  - Else `cnt` != `div_reg`: `cnt` increments.
  - Else, if `sel` != 15: `cnt`=0, `sel` increments, and `bit_out`=`pat_reg[15-(sel+1)]`.
  - Else, at pattern end: `cnt`=0 and `done`=1 next cycle. The rest depends on Configuration.
- Counter arithmetic:
  - `cnt` compares by equality against `div_reg` and never wraps past it.
  - With `div`=0, every cycle advances one bit.
  - With `div`=2^DIV_WIDTH−1, the bit period is 2^DIV_WIDTH cycles.
- Outside the reload window, `pat_valid` while in RUN is ignored (`pat_ready`=0). A held `pat_data` is not consumed.
- `busy` is 1 exactly when `state`=RUN.
- `done` is registered and cleared on the following cycle.

## Timing
- Handshake at edge N: at edge N, `busy`=1, `sel`=0, and `bit_out`=pattern bit 15.
- Each bit is held for `div`+1 cycles, so a full pattern lasts 16·(`div`+1) cycles.
- `sel` and `bit_out` change on the same edge; `bit_out` never lags `sel`.
- One-shot completion: at the edge ending bit 15, `busy`=0, `bit_out`=0, `sel`=0 and `done`=1. `pat_ready`=1 in that same following cycle.
  - The minimum gap between patterns is one idle cycle with `bit_out`=0.
- `stop` takes effect at the next edge from any cycle in RUN, including the final cycle of bit 15. In that case there is no `done` and no reload.
- Reset asserted mid-run clears all state immediately, without waiting for a clock edge.

## Configuration
- Macro: `BLINK_LOOP_EN`.
- Undefined (one-shot): at pattern end, state→IDLE as described in Timing.
- Defined (loop): at pattern end, the sequencer stays in RUN.
  - `sel` wraps 15→0, `bit_out`=`pat_reg[15]`, and `done` pulses every wrap.
  - `pat_ready` is additionally 1 during the final cycle of bit 15 when `stop`=0.
  - A handshake in that cycle loads the new `pat_data` and `div` at the wrap edge, with no gap, and `done` still pulses.
  - Playback only ends on `stop` or reset.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge → `sel`=0, `bit_out`=0, `busy`=0, `done`=0, `pat_ready`=1 immediately.
- One-shot, `pat_data`=0xA5F0, `div`=0:
  - `bit_out` = 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 on 16 consecutive cycles, with `sel` stepping 0..15.
  - Then `done`=1 for one cycle, `busy`=0 and `bit_out`=0.
- `pat_data`=0x8001, `div`=2:
  - `bit_out`=1 for 3 cycles, 0 for 42 cycles, then 1 for 3 cycles; total 48 cycles to `done`.
  - Changing the `div` input mid-run has no effect.
- `stop` asserted at `sel`=7 with `div`=3 → next edge `busy`=0, `bit_out`=0, `sel`=0, and `done` stays 0.
  - A later `pat_valid` restarts playback from bit 15.
- Without the macro, `pat_valid` held high throughout a run → `pat_ready`=0 while `busy`.
  - The second pattern starts exactly one cycle after `done`.
- With `BLINK_LOOP_EN`, 0xFFFF is followed by 0x0000 (`div`=1), offered during the last cycle of bit 15.
  - `bit_out` goes from 1 to 0 at the wrap edge with no idle cycle, and `done` pulses once at the wrap.

Source files
------------

// File: rtl/blink_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// blink_pattern_sequencer
//
// Plays a 16-bit blink pattern out one bit at a time, MSB first. A pattern
// and its bit period are accepted over a valid/ready handshake. The 4-bit
// select steps 0..15 and drives the external 16:1 mux, which returns
// a[15-sel]. A registered copy of the selected bit is provided for the LED.
//
// Optional feature macro: BLINK_LOOP_EN
//   undefined : one-shot playback, returns to IDLE after bit 15
//   defined   : loops forever, with a gapless reload window in the final
//               cycle of bit 15; only stop or reset ends playback
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   pat_valid  new pattern offered
//   pat_ready  sequencer can accept a pattern this cycle
//   pat_data   pattern, bit 15 played first
//   div        bit period minus one in clk cycles, sampled at handshake
//   stop       abort playback (ignored in IDLE)
//   sel        current bit index, feeds the mux select
//   bit_out    registered pat_reg[15-sel] while running, 0 when idle
//   busy       high while playing
//   done       one-cycle pulse at pattern completion
// ---------------------------------------------------------------------------
module blink_pattern_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [15:0]          pat_data,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 stop,
    output logic [3:0]           sel,
    output logic                 bit_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [15:0]          pat_reg, pat_reg_n;
    logic [DIV_WIDTH-1:0] div_reg, div_reg_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [3:0]           sel_n;
    logic                 bit_out_n;
    logic                 done_n;
    logic [3:0]           sel_inc;
    logic                 last_cycle;

    // Final cycle of bit 15: the period counter has reached its terminal
    // value on the last select position. This is where a pattern ends and,
    // in loop mode, where the reload window opens.
    always_comb begin
        sel_inc    = sel + 4'd1;
        last_cycle = (state == RUN) && (cnt == div_reg) && (sel == 4'd15);
    end

    // Handshake acceptance and busy flag. Both are decoded straight from the
    // state register so that reset makes pat_ready visible immediately.
    always_comb begin
        busy = (state == RUN);
`ifdef BLINK_LOOP_EN
        pat_ready = (state == IDLE) || (last_cycle && !stop);
`else
        pat_ready = (state == IDLE);
`endif
    end

    // Next-state and next-output logic. Everything holds by default and done
    // defaults low so it only pulses for the one cycle after completion.
    // In RUN, stop has top priority, then the period counter, then the bit
    // step, and finally the end-of-pattern behaviour.
    always_comb begin
        state_n   = state;
        pat_reg_n = pat_reg;
        div_reg_n = div_reg;
        cnt_n     = cnt;
        sel_n     = sel;
        bit_out_n = bit_out;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (pat_valid) begin
                    state_n   = RUN;
                    pat_reg_n = pat_data;
                    div_reg_n = div;
                    cnt_n     = '0;
                    sel_n     = 4'd0;
                    bit_out_n = pat_data[15];
                end
            end

            RUN: begin
                if (stop) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    sel_n     = 4'd0;
                    bit_out_n = 1'b0;
                end else if (cnt != div_reg) begin
                    cnt_n = cnt + DIV_WIDTH'(1);
                end else if (!last_cycle) begin
                    cnt_n     = '0;
                    sel_n     = sel_inc;
                    bit_out_n = pat_reg[4'd15 - sel_inc];
                end else begin
                    cnt_n  = '0;
                    sel_n  = 4'd0;
                    done_n = 1'b1;
`ifdef BLINK_LOOP_EN
                    // Wrap to bit 15, either of the current pattern or of a
                    // pattern handed over in this very cycle.
                    if (pat_valid) begin
                        pat_reg_n = pat_data;
                        div_reg_n = div;
                        bit_out_n = pat_data[15];
                    end else begin
                        bit_out_n = pat_reg[15];
                    end
`else
                    state_n   = IDLE;
                    bit_out_n = 1'b0;
`endif
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pat_reg <= '0;
            div_reg <= '0;
            cnt     <= '0;
            sel     <= 4'd0;
            bit_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pat_reg <= pat_reg_n;
            div_reg <= div_reg_n;
            cnt     <= cnt_n;
            sel     <= sel_n;
            bit_out <= bit_out_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_blink_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_blink_pattern_sequencer
//
// Scoreboard bench for blink_pattern_sequencer. Each accepted pattern is
// expanded by a simple model into the per-cycle outputs it should produce
// (bit i of the playback shown for div+1 cycles, then a done cycle in
// one-shot mode). A monitor on the falling edge pops one entry whenever the
// DUT is busy or pulsing done, and checks idle outputs otherwise.
// Compile with +define+BLINK_LOOP_EN to exercise loop mode.
// ---------------------------------------------------------------------------
module tb_blink_pattern_sequencer;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          pat_valid;
    logic          pat_ready;
    logic [15:0]   pat_data;
    logic [DW-1:0] div;
    logic          stop;
    logic [3:0]    sel;
    logic          bit_out;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       busy;
        logic [3:0] sel;
        logic       bitv;
        logic       done;
        logic       last;
    } exp_t;

    exp_t expQ[$];

    blink_pattern_sequencer #(.DIV_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .div       (div),
        .stop      (stop),
        .sel       (sel),
        .bit_out   (bit_out),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expand one accepted pattern into its expected per-cycle outputs.
    function automatic void pushPattern(input logic [15:0] data, input int d,
                                        input logic wrapDone);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j <= d; j++) begin
                e.busy = 1'b1;
                e.sel  = 4'(i);
                e.bitv = data[15 - i];
                e.done = (i == 0 && j == 0) ? wrapDone : 1'b0;
                e.last = (i == 15 && j == d);
                expQ.push_back(e);
            end
        end
`ifndef BLINK_LOOP_EN
        e = '{busy: 1'b0, sel: 4'd0, bitv: 1'b0, done: 1'b1, last: 1'b0};
        expQ.push_back(e);
`endif
    endfunction

    // Monitor: compares DUT outputs against the scoreboard on each falling
    // edge, well away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic expReady;
        if (!rst) begin
            checks++;
            if (busy || done) begin
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: busy=%0b sel=%0d bit=%0b done=%0b, expected idle",
                             busy, sel, bit_out, done);
                end else begin
                    e = expQ.pop_front();
`ifdef BLINK_LOOP_EN
                    expReady = !e.busy || (e.last && !stop);
`else
                    expReady = !e.busy;
`endif
                    if (busy !== e.busy || sel !== e.sel || bit_out !== e.bitv ||
                        done !== e.done || pat_ready !== expReady) begin
                        errors++;
                        $display("[TB] FAIL playback @%0t: busy=%0b sel=%0d bit=%0b done=%0b ready=%0b, expected busy=%0b sel=%0d bit=%0b done=%0b ready=%0b",
                                 $time, busy, sel, bit_out, done, pat_ready,
                                 e.busy, e.sel, e.bitv, e.done, expReady);
                    end
                end
            end else begin
                if (expQ.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL missing_activity @%0t: DUT idle, expected %0d more cycles",
                             $time, expQ.size());
                    expQ.delete();
                end else if (sel !== 4'd0 || bit_out !== 1'b0 || pat_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL idle_outputs @%0t: sel=%0d bit=%0b ready=%0b, expected sel=0 bit=0 ready=1",
                             $time, sel, bit_out, pat_ready);
                end
            end
        end
    end

    // Compare the full output set against the reset values.
    task automatic checkOutput(input string name);
        checks++;
        if (sel !== 4'd0 || bit_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pat_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: sel=%0d bit=%0b busy=%0b done=%0b ready=%0b, expected 0 0 0 0 1",
                     name, sel, bit_out, busy, done, pat_ready);
        end
    endtask

    // Offer a pattern from IDLE, then let it run out or stop it at cycle
    // stopAt (counted from the handshake edge). Called at posedge+1.
    // The div and pat_data inputs are scrambled after the handshake to show
    // that only the sampled values matter.
    task automatic applyStimulus(input logic [15:0] data, input int d, input int stopAt);
        int total;
        int sa;
        total = 16 * (d + 1);
        sa    = stopAt;
`ifdef BLINK_LOOP_EN
        if (sa < 0) sa = total - 1;
`endif
        pat_valid = 1'b1;
        pat_data  = data;
        div       = DW'(d);
        @(posedge clk);
        pushPattern(data, d, 1'b0);
        #1;
        pat_valid = 1'b0;
        pat_data  = 16'($urandom);
        div       = DW'($urandom);
        if (sa >= 0) begin
            repeat (sa) @(posedge clk);
            #1 stop = 1'b1;
            @(posedge clk);
            expQ.delete();
            #1 stop = 1'b0;
            repeat (2) @(posedge clk);
        end else begin
            repeat (total + 2) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        logic [15:0] rdata;
        int          rd;

        rst       = 1'b1;
        pat_valid = 1'b0;
        pat_data  = 16'h0;
        div       = '0;
        stop      = 1'b0;
        #1 checkOutput("power_on_reset");
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Stop is ignored while idle.
        stop = 1'b1;
        repeat (2) @(posedge clk);
        #1 stop = 1'b0;

        applyStimulus(16'hA5F0, 0, -1);
        applyStimulus(16'h8001, 2, -1);
        // Stop in the middle of bit index 7, then restart from bit 15.
        applyStimulus(16'h5A3C, 3, 7 * 4 + 1);
        applyStimulus(16'hC3E1, 1, -1);
        // Largest bit period this divider width allows.
        applyStimulus(16'h9B6D, (1 << DW) - 1, -1);
        // Stop in the very first and very last cycles of playback.
        applyStimulus(16'hFFFF, 1, 0);
        applyStimulus(16'hFFFF, 1, 31);

`ifndef BLINK_LOOP_EN
        // Valid held through a run: the second pattern waits and starts
        // straight after the done cycle.
        pat_valid = 1'b1;
        pat_data  = 16'hB00F;
        div       = DW'(1);
        @(posedge clk);
        pushPattern(16'hB00F, 1, 1'b0);
        #1;
        pat_data = 16'h6E71;
        div      = DW'(0);
        repeat (32) @(posedge clk);
        @(posedge clk);
        pushPattern(16'h6E71, 0, 1'b0);
        #1 pat_valid = 1'b0;
        repeat (18) @(posedge clk);
        #1;
`else
        // Gapless reload: 0xFFFF then 0x0000, both div=1, the second offered
        // in the final cycle of bit 15, then stopped at its own final cycle.
        pat_valid = 1'b1;
        pat_data  = 16'hFFFF;
        div       = DW'(1);
        @(posedge clk);
        pushPattern(16'hFFFF, 1, 1'b0);
        #1 pat_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        pat_valid = 1'b1;
        pat_data  = 16'h0000;
        div       = DW'(1);
        @(posedge clk);
        pushPattern(16'h0000, 1, 1'b1);
        #1 pat_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Randomized patterns, periods and stop points.
        for (int k = 0; k < 8; k++) begin
            rdata = 16'($urandom);
            rd    = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                applyStimulus(rdata, rd, int'($urandom_range(0, 16 * (rd + 1) - 1)));
            else
                applyStimulus(rdata, rd, -1);
        end

        // Asynchronous reset in the middle of a run, between clock edges.
        pat_valid = 1'b1;
        pat_data  = 16'hF00F;
        div       = DW'(1);
        @(posedge clk);
        pushPattern(16'hF00F, 1, 1'b0);
        #1 pat_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_mid_run");
        expQ.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // A fresh pattern after reset plays normally.
        applyStimulus(16'h1234, 0, -1);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
